// File: rtl/la_rx_port.sv
// Router input port: lookahead-routed flit FIFO with prefer-port vector checking,
// head-age tracking and credit return to the upstream router.
module la_rx_port #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int NUM_PORT   = 5,
  parameter int AGE_MAX    = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_flit,
  input  logic [NUM_PORT-1:0]              in_ppv,
  output logic                             credit_out,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_flit,
  output logic [NUM_PORT-1:0]              out_ppv,
  output logic [$clog2(AGE_MAX+1)-1:0]     out_age,
  input  logic                             sa_grant,
  output logic                             err_ppv,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(AGE_MAX + 1);
  localparam int CW = OW + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  function automatic logic is_onehot(input logic [NUM_PORT-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  logic [DATA_WIDTH-1:0] flit_mem [DEPTH];
  logic [NUM_PORT-1:0]   ppv_mem  [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] credit_pend;
  logic [CW-1:0] credit_total;
  state_t        state_q, state_d;

  logic ppv_ok, full, pop, push, drop_bad, drop_full;

  assign ppv_ok    = is_onehot(in_ppv);
  assign full      = (occupancy == OW'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign pop       = sa_grant && out_valid;
  assign push      = in_valid && ppv_ok && (!full || pop);
  assign drop_bad  = in_valid && !ppv_ok;
  assign drop_full = in_valid && ppv_ok && full && !pop;

  assign out_flit = flit_mem[rd_ptr];
  assign out_ppv  = ppv_mem[rd_ptr];

  // A pop and an invalid-flit drop in the same cycle owe two credits; the
  // second one is queued and sent on the following cycle.
  assign credit_total = credit_pend + CW'(pop) + CW'(drop_bad);

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem[wr_ptr] <= in_flit;
      ppv_mem[wr_ptr]  <= in_ppv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      credit_out  <= 1'b0;
      credit_pend <= '0;
      err_ppv     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      credit_out  <= (credit_total != '0);
      credit_pend <= credit_total - CW'(credit_total != '0);
      if (drop_bad || drop_full) err_ppv <= 1'b1;
    end
  end

  // Age restarts whenever a different flit becomes head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_age <= '0;
    end else if (pop || (push && !out_valid)) begin
      out_age <= '0;
    end else if (state_q == ACTIVE && out_age != GW'(AGE_MAX)) begin
      out_age <= out_age + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = ACTIVE;
      ACTIVE:  if (pop && !push && occupancy == OW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_la_rx_port.sv
// Directed self-checking bench for la_rx_port (default parameters).
module tb_la_rx_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_flit;
  logic [4:0]  in_ppv;
  logic        credit_out;
  logic        out_valid;
  logic [63:0] out_flit;
  logic [4:0]  out_ppv;
  logic [3:0]  out_age;
  logic        sa_grant;
  logic        err_ppv;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  la_rx_port dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit),
    .in_ppv(in_ppv), .credit_out(credit_out), .out_valid(out_valid),
    .out_flit(out_flit), .out_ppv(out_ppv), .out_age(out_age),
    .sa_grant(sa_grant), .err_ppv(err_ppv), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_flit  = '0;
    in_ppv   = '0;
    sa_grant = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #2;
  endtask

  task automatic push(input logic [63:0] f, input logic [4:0] p);
    in_valid = 1'b1; in_flit = f; in_ppv = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (out_age !== 4'd0) begin errors++; $display("FAIL reset_age: got %0d want 0", out_age); end
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL reset_credit: got %b want 0", credit_out); end
    checks++; if (err_ppv !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_ppv); end
    step();
    rst_n = 1'b1;
    #2;
  endtask

  task automatic test_single();
    do_reset();
    push(64'hA5, 5'b00010);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_flit !== 64'hA5) begin errors++; $display("FAIL single_flit: got %h want a5", out_flit); end
    checks++; if (out_ppv !== 5'b00010) begin errors++; $display("FAIL single_ppv: got %b want 00010", out_ppv); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    checks++; if (out_age !== 4'd0) begin errors++; $display("FAIL single_age0: got %0d want 0", out_age); end
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL single_nocredit: got %b want 0", credit_out); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (out_age !== 4'(i)) begin errors++; $display("FAIL single_age: got %0d want %0d", out_age, i); end
    end
    sa_grant = 1'b1;
    step();
    sa_grant = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
    checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL single_pop_credit: got %b want 1", credit_out); end
    checks++; if (out_age !== 4'd0) begin errors++; $display("FAIL single_pop_age: got %0d want 0", out_age); end
    sa_grant = 1'b1;
    step();
    sa_grant = 1'b0;
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL single_credit_end: got %b want 0", credit_out); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_empty_grant: got %0d want 0", occupancy); end
  endtask

  task automatic test_bad_ppv();
    logic [4:0] bad [2];
    bad[0] = 5'b00000;
    bad[1] = 5'b10010;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(64'h100 + 64'(i), bad[i]);
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL bad_occ[%0d]: got %0d want 0", i, occupancy); end
      checks++; if (err_ppv !== 1'b1) begin errors++; $display("FAIL bad_err[%0d]: got %b want 1", i, err_ppv); end
      checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL bad_credit[%0d]: got %b want 1", i, credit_out); end
      step();
      checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL bad_credit_end[%0d]: got %b want 0", i, credit_out); end
    end
  endtask

  task automatic drain(input string tag, input logic [63:0] exp [4]);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_flit !== exp[i]) begin errors++; $display("FAIL %s_order[%0d]: got %h want %h", tag, i, out_flit, exp[i]); end
      sa_grant = 1'b1;
      step();
      sa_grant = 1'b0;
      checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL %s_drain_credit[%0d]: got %b want 1", tag, i, credit_out); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b want 0", tag, out_valid); end
  endtask

  task automatic test_full_drop();
    logic [63:0] exp [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(64'(i + 1), 5'b00001);
      exp[i] = 64'(i + 1);
    end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d want 4", occupancy); end
    checks++; if (err_ppv !== 1'b0) begin errors++; $display("FAIL full_err_pre: got %b want 0", err_ppv); end
    push(64'h5, 5'b00001);
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_drop_occ: got %0d want 4", occupancy); end
    checks++; if (err_ppv !== 1'b1) begin errors++; $display("FAIL full_drop_err: got %b want 1", err_ppv); end
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL full_drop_credit: got %b want 0", credit_out); end
    step();
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL full_drop_credit2: got %b want 0", credit_out); end
    drain("full", exp);
  endtask

  task automatic test_full_push_pop();
    logic [63:0] exp [4];
    do_reset();
    for (int i = 0; i < 4; i++) push(64'h10 + 64'(i), 5'b01000);
    in_valid = 1'b1; in_flit = 64'h14; in_ppv = 5'b00100; sa_grant = 1'b1;
    step();
    idle_inputs();
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL pp_occ: got %0d want 4", occupancy); end
    checks++; if (out_flit !== 64'h11) begin errors++; $display("FAIL pp_head: got %h want 11", out_flit); end
    checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL pp_credit: got %b want 1", credit_out); end
    checks++; if (err_ppv !== 1'b0) begin errors++; $display("FAIL pp_err: got %b want 0", err_ppv); end
    exp[0] = 64'h11; exp[1] = 64'h12; exp[2] = 64'h13; exp[3] = 64'h14;
    drain("pp", exp);
  endtask

  task automatic test_age_sat();
    do_reset();
    push(64'h77, 5'b10000);
    push(64'h88, 5'b00001);
    checks++; if (out_age !== 4'd1) begin errors++; $display("FAIL age_second_push: got %0d want 1", out_age); end
    for (int i = 0; i < 20; i++) step();
    checks++; if (out_age !== 4'd15) begin errors++; $display("FAIL age_sat: got %0d want 15", out_age); end
    sa_grant = 1'b1;
    step();
    sa_grant = 1'b0;
    checks++; if (out_flit !== 64'h88) begin errors++; $display("FAIL age_new_head: got %h want 88", out_flit); end
    checks++; if (out_age !== 4'd0) begin errors++; $display("FAIL age_restart: got %0d want 0", out_age); end
    step();
    checks++; if (out_age !== 4'd1) begin errors++; $display("FAIL age_count: got %0d want 1", out_age); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(64'h21, 5'b00100);
    in_valid = 1'b1; in_flit = 64'h22; in_ppv = 5'b00000; sa_grant = 1'b1;
    step();
    idle_inputs();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_occ: got %0d want 0", occupancy); end
    checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL b2b_credit1: got %b want 1", credit_out); end
    step();
    checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL b2b_credit2: got %b want 1", credit_out); end
    step();
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL b2b_credit3: got %b want 0", credit_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push(64'h30 + 64'(i), 5'b00010);
    sa_grant = 1'b1;
    step();
    sa_grant = 1'b0;
    checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL mid_credit_pre: got %b want 1", credit_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_occ: got %0d want 0", occupancy); end
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL mid_credit: got %b want 0", credit_out); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL mid_post_credit[%0d]: got %b want 0", i, credit_out); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_ppv();
    test_full_drop();
    test_full_push_pop();
    test_age_sat();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
